ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit for the execute stage, directly upstream of the memory stage. It accepts one M-extension operation from the ID/EX register and holds the pipeline while it computes. It then presents a one-cycle result beat that the execute stage muxes onto its `res`/`rd` path into the EX/MEM register. The datapath is a radix-2 shift-add/shift-subtract engine running on operand magnitudes, with the sign corrected at the end.

## Interface
- `XLEN`, 32, operand and result width. Only 32 is supported.
- `i_clk` in 1: the single clock.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_vld` in 1: an M-extension instruction is present; sampled only in IDLE.
- `i_funct3` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_op_a` in 32: rs1 operand (forwarded value).
- `i_op_b` in 32: rs2 operand (forwarded value).
- `i_rd_waddr` in 5: destination register.
- `i_flush` in 1: synchronous kill from branch/trap redirect.
- `o_busy` out 1: stall request to IF/ID/EX.
- `o_vld` out 1: result beat, one cycle.
- `o_res` out 32: result, valid while `o_vld` is high.
- `o_rd_waddr` out 5: destination for the result.
- `o_rd_wen` out 1: equals `o_vld` when `o_rd_waddr` is non-zero.

## Operation
- **States.**
  - IDLE: waits for work.
  - CALC: 32 iterations.
  - FIX: sign correction and output registration.
- **IDLE → CALC** when `i_vld` is high and `i_flush` is low.
  - Latch `funct3` and `rd`.
  - Latch `|a|` and `|b|`, taking a magnitude only for signed operands. MULHSU treats `b` as unsigned.
  - Latch the result-sign flag:
    - multiply: `a_s ^ b_s`;
    - DIV: `a_s ^ b_s`;
    - REM: `a_s`.
  - Clear the 6-bit iteration counter.
- **IDLE → FIX (fast path)**, taken in the same accept cycle:
  - divide by zero: quotient `0xFFFFFFFF`, remainder = `a`;
  - signed overflow (`a=0x80000000`, `b=0xFFFFFFFF`, DIV or REM): quotient `0x80000000`, remainder 0.
- **CALC, multiply:** a 64-bit {hi,lo} accumulator.
  - Each cycle, if `lo[0]` is set, add the multiplicand into `hi` with a 33-bit carry.
  - Then shift the accumulator right by 1.
- **CALC, divide:** restoring division.
  - Shift {rem,quot} left by 1.
  - If `rem ≥ |b|`, subtract `|b|` and set `quot[0]`.
- **CALC → FIX** when the counter reaches 31, i.e. 32 iterations have completed.
- **FIX:**
  - If the sign flag is set, negate the 64-bit product or the chosen 32-bit quotient/remainder (two's complement).
  - Select the result:
    - MUL: low 32 bits;
    - MULH, MULHSU, MULHU: high 32 bits;
    - DIV, DIVU: quotient;
    - REM, REMU: remainder.
  - Register `o_res`, `o_rd_waddr` and `o_vld=1`, then return to IDLE.
- **Flush:**
  - `i_flush` in any state forces IDLE on the next edge, with no `o_vld`.
  - Flush has priority over accepting new work and over FIX.
- **Unused bits:** all arithmetic is unsigned on magnitudes. MULH, MULHSU and MULHU discard no carry beyond bit 63.

## Timing
- **Reset values:**
  - state IDLE;
  - `o_busy=0`, `o_vld=0`, `o_rd_wen=0`;
  - `o_res=0`, `o_rd_waddr=0`;
  - internal registers 0.
- **Reset mid-operation** aborts immediately with no result beat.
- **`o_busy`:**
  - It is combinational: `(state==IDLE & i_vld & ~i_flush) | (state!=IDLE & ~o_vld_next)`.
  - Upstream therefore freezes in the accept cycle.
  - `o_busy` falls in the cycle the result is registered, so the next instruction advances as `o_vld` appears.
- **Normal latency**, with accept at edge E:
  - iterations at edges E+1 … E+32;
  - FIX registers at E+33;
  - `o_vld` is high during the cycle after E+33;
  - total 33 stall cycles.
- **Fast path:** FIX at E+1, with `o_vld` high the cycle after E+1.
- **Back-to-back:** `i_vld` is high in the same cycle as `o_vld`. The new operation is accepted at that cycle's edge; there are no idle bubbles.
- **`o_vld` is exactly one cycle.** It is never asserted in the same cycle as, or after, a flush.

## Structure
- **Shared package `rv_pkg`** holds:
  - the `funct3` M-op encodings;
  - the state encoding;
  - the localparams for the divide-by-zero quotient (`0xFFFFFFFF`) and INT_MIN (`0x80000000`).
- **Sub-module `muldiv_core`** contains the iteration datapath and counter.
  - It has a start/done interface on magnitudes and an op-class bit.
- **`ex_muldiv`** owns:
  - the FSM;
  - sign handling;
  - the fast paths;
  - the output registers.

## Test plan
- MUL, `a=7`, `b=-3` (`0xFFFFFFFD`) → one `o_vld`, 34 cycles after accept, with `o_res=0xFFFFFFEB`. `o_busy` is high for exactly 33 cycles.
- MULHU with `a=b=0xFFFFFFFF` → `0xFFFFFFFE`. MULH with the same operands → `0x00000000`. MULHSU with `a=-1`, `b=0xFFFFFFFF` → `0xFFFFFFFF`.
- DIV `-7/2` → `0xFFFFFFFD`; REM `-7/2` → `0xFFFFFFFF`; DIVU `100/7` → 14; REMU `100/7` → 2.
- Divide by zero: DIV `5/0` → `0xFFFFFFFF` and REM `5/0` → 5, with result latency 2 cycles. Overflow: DIV `0x80000000/-1` → `0x80000000` and REM → 0.
- `i_flush` pulsed at iteration 10 → no `o_vld` and state back in IDLE. `i_rst` driven low at iteration 20 → all outputs are 0 asynchronously.
- Back-to-back DIVU then MUL with `i_vld` held high → the second operation is accepted in the `o_vld` cycle, with no gap. A result to `rd=x0` → `o_vld=1`, `o_rd_wen=0`.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32M definitions for the execute-stage multiply/divide unit:
// funct3 encodings, FSM states, corner-case constants and small op decoders.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } m_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // MULHSU keeps rs1 signed but treats rs2 as unsigned.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface ex_muldiv_if;
    import rv_pkg::*;

    logic            i_vld;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic [4:0]      i_rd_waddr;
    logic            i_flush;

    logic            o_busy;
    logic            o_vld;
    logic [XLEN-1:0] o_res;
    logic [4:0]      o_rd_waddr;
    logic            o_rd_wen;

    modport master (
        output i_vld, i_funct3, i_op_a, i_op_b, i_rd_waddr, i_flush,
        input  o_busy, o_vld, o_res, o_rd_waddr, o_rd_wen
    );

    modport slave (
        input  i_vld, i_funct3, i_op_a, i_op_b, i_rd_waddr, i_flush,
        output o_busy, o_vld, o_res, o_rd_waddr, o_rd_wen
    );

endinterface

// File: rtl/muldiv_core.sv
// Radix-2 iteration engine on unsigned magnitudes: shift-add multiply or
// restoring divide, 32 iterations, result left in a 64-bit accumulator.
module muldiv_core
    import rv_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_mag_a,
    input  logic [XLEN-1:0]   i_mag_b,
    output logic              o_last,
    output logic [2*XLEN-1:0] o_acc
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd_b;
    logic              is_div;
    logic [5:0]        cnt;
    logic              active;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] div_next;

    // Multiply keeps {hi,lo}; divide keeps {rem,quot}. The shifted partial
    // remainder needs 33 bits because |b| may use all 32.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_b} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        rem_sh   = acc[2*XLEN-1:XLEN-1];
        rem_ge   = (rem_sh >= {1'b0, opnd_b});
        rem_diff = rem_sh[XLEN-1:0] - opnd_b;
        div_next = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc    <= '0;
            opnd_b <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (i_abort) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (i_start) begin
            acc    <= {{XLEN{1'b0}}, i_mag_a};
            opnd_b <= i_mag_b;
            is_div <= i_is_div;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc <= is_div ? div_next : mul_next;
            if (cnt == 6'd31) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    assign o_last = active & (cnt == 6'd31);
    assign o_acc  = acc;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the execute stage: stalls the pipeline
// while muldiv_core iterates, then emits a one-cycle signed-corrected result.
module ex_muldiv
    import rv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    ex_muldiv_if.slave bus
);

    md_state_e         state;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic              sign;
    logic              fast;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN-1:0]   res_q;
    logic [4:0]        rd_q;
    logic              vld_q;
    logic              wen_q;

    logic              accept;
    logic              a_s;
    logic              b_s;
    logic              div_zero;
    logic              ovf;
    logic              fast_hit;
    logic              sign_next;
    logic              core_start;
    logic              core_is_div;
    logic              core_last;
    logic              vld_next;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   fast_val;
    logic [XLEN-1:0]   div_pick;
    logic [XLEN-1:0]   div_fix;
    logic [XLEN-1:0]   res_next;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod_fix;

    // Decode the incoming request; only meaningful while IDLE.
    always_comb begin
        accept      = (state == ST_IDLE) & bus.i_vld & ~bus.i_flush;
        a_s         = op_signed_a(bus.i_funct3) & bus.i_op_a[XLEN-1];
        b_s         = op_signed_b(bus.i_funct3) & bus.i_op_b[XLEN-1];
        mag_a       = a_s ? -bus.i_op_a : bus.i_op_a;
        mag_b       = b_s ? -bus.i_op_b : bus.i_op_b;
        div_zero    = (bus.i_op_b == '0);
        ovf         = ((bus.i_funct3 == F3_DIV) || (bus.i_funct3 == F3_REM)) &&
                      (bus.i_op_a == INT_MIN) && (bus.i_op_b == '1);
        fast_hit    = op_is_div(bus.i_funct3) & (div_zero | ovf);
        sign_next   = op_is_rem(bus.i_funct3) ? a_s : (a_s ^ b_s);
        core_is_div = op_is_div(bus.i_funct3);
        core_start  = accept & ~fast_hit;
        if (op_is_rem(bus.i_funct3)) begin
            fast_val = div_zero ? bus.i_op_a : '0;
        end else begin
            fast_val = div_zero ? DIV_ZERO_QUOT : INT_MIN;
        end
    end

    muldiv_core u_core (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (core_start),
        .i_abort  (bus.i_flush),
        .i_is_div (core_is_div),
        .i_mag_a  (mag_a),
        .i_mag_b  (mag_b),
        .o_last   (core_last),
        .o_acc    (acc)
    );

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        prod_fix = sign ? -acc : acc;
        div_pick = op_is_rem(funct3) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        div_fix  = sign ? -div_pick : div_pick;
        res_next = '0;
        case (funct3)
            F3_MUL:                        res_next = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  res_next = prod_fix[2*XLEN-1:XLEN];
            default:                       res_next = div_fix;
        endcase
        if (fast) begin
            res_next = fast_res;
        end
        vld_next = (state == ST_FIX) & ~bus.i_flush;
    end

    // Flush wins over everything, including a pending FIX.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            funct3   <= '0;
            rd       <= '0;
            sign     <= 1'b0;
            fast     <= 1'b0;
            fast_res <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            vld_q    <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            wen_q <= 1'b0;
            if (bus.i_flush) begin
                state <= ST_IDLE;
                fast  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.i_vld) begin
                            funct3   <= bus.i_funct3;
                            rd       <= bus.i_rd_waddr;
                            sign     <= sign_next;
                            fast     <= fast_hit;
                            fast_res <= fast_val;
                            state    <= fast_hit ? ST_FIX : ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (core_last) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        res_q <= res_next;
                        rd_q  <= rd;
                        vld_q <= 1'b1;
                        wen_q <= (rd != 5'd0);
                        fast  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Busy drops in the FIX cycle so the next instruction lines up with o_vld.
    assign bus.o_busy     = i_rst & (accept | ((state != ST_IDLE) & ~vld_next));
    assign bus.o_vld      = vld_q;
    assign bus.o_res      = res_q;
    assign bus.o_rd_waddr = rd_q;
    assign bus.o_rd_wen   = wen_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of expected results, one task
// per scenario, reference model computed with 64-bit arithmetic.
module tb_ex_muldiv;
    import rv_pkg::*;

    logic clk;
    logic rst_n;

    ex_muldiv_if bus();

    ex_muldiv dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } op_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic [63:0]        p;
        logic signed [31:0] q;
        logic               ov;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ov  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request for a single cycle, starting at a negedge.
    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  input logic [31:0] exp_res, input bit expect_out,
                                  output logic busy_acc);
        exp_t e;
        bus.i_vld      = 1'b1;
        bus.i_funct3   = f3;
        bus.i_op_a     = a;
        bus.i_op_b     = b;
        bus.i_rd_waddr = rd;
        if (expect_out) begin
            e.res = exp_res;
            e.rd  = rd;
            e.wen = (rd != 5'd0);
            sb.push_back(e);
        end
        #1 busy_acc = bus.o_busy;
        @(negedge clk);
        bus.i_vld = 1'b0;
    endtask

    // Wait (bounded) for a result beat; lat counts negedges after the accept edge.
    task automatic wait_result(output logic found, output logic [31:0] res,
                               output logic [4:0] rd, output logic wen,
                               output int lat, output int busy_cnt,
                               output logic vld_after);
        found = 1'b0; res = '0; rd = '0; wen = 1'b0;
        lat = 0; busy_cnt = 0; vld_after = 1'b0;
        for (int k = 1; k <= 60 && !found; k++) begin
            if (bus.o_vld) begin
                found = 1'b1;
                lat   = k;
                res   = bus.o_res;
                rd    = bus.o_rd_waddr;
                wen   = bus.o_rd_wen;
            end else begin
                if (bus.o_busy) busy_cnt++;
                @(negedge clk);
            end
        end
        if (found) begin
            @(negedge clk);
            vld_after = bus.o_vld;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.o_busy, bus.o_vld, bus.o_rd_wen, bus.o_res, bus.o_rd_waddr} !== 40'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got busy=%b vld=%b wen=%b res=%h rd=%0d expected all 0",
                     bus.o_busy, bus.o_vld, bus.o_rd_wen, bus.o_res, bus.o_rd_waddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_busy, bus.o_vld, bus.o_rd_wen, bus.o_res} !== 35'd0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got busy=%b vld=%b wen=%b res=%h expected 0",
                     bus.o_busy, bus.o_vld, bus.o_rd_wen, bus.o_res);
        end
    endtask

    task automatic test_mul();
        logic found, wen, vld_after, busy_acc;
        logic [31:0] res;
        logic [4:0]  rd;
        int lat, busy_cnt;
        exp_t e;
        apply_stimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, busy_acc);
        wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
        e = sb.pop_front();
        n_cmp++;
        if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL mul_timeout: no o_vld within 60 cycles"); end
        n_cmp++;
        if (res !== e.res) begin n_fail++; $display("[TB] FAIL mul_res: got %h expected %h", res, e.res); end
        n_cmp++;
        if ({rd, wen} !== {e.rd, e.wen}) begin
            n_fail++; $display("[TB] FAIL mul_rd: got rd=%0d wen=%b expected rd=%0d wen=%b", rd, wen, e.rd, e.wen);
        end
        n_cmp++;
        if (lat !== 34) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d expected 34", lat); end
        n_cmp++;
        if (busy_cnt + int'(busy_acc) !== 33) begin
            n_fail++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 33", busy_cnt + int'(busy_acc));
        end
        n_cmp++;
        if (vld_after !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_vld_width: got o_vld=%b a cycle later expected 0", vld_after); end
    endtask

    task automatic test_mul_high();
        op_t ops[3] = '{
            '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}
        };
        logic found, wen, vld_after, busy_acc;
        logic [31:0] res;
        logic [4:0]  rd;
        int lat, busy_cnt;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(ops[i].f3, ops[i].a, ops[i].b, 5'd10 + 5'(i), ops[i].res, 1'b1, busy_acc);
            wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
            e = sb.pop_front();
            n_cmp++;
            if ({found, res} !== {1'b1, e.res}) begin
                n_fail++; $display("[TB] FAIL mulh_res[%0d]: got found=%b res=%h expected %h", i, found, res, e.res);
            end
            n_cmp++;
            if (rd !== e.rd) begin n_fail++; $display("[TB] FAIL mulh_rd[%0d]: got %0d expected %0d", i, rd, e.rd); end
        end
    endtask

    task automatic test_div();
        op_t ops[4] = '{
            '{F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
            '{F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
            '{F3_DIVU, 32'd100,       32'd7, 32'd14},
            '{F3_REMU, 32'd100,       32'd7, 32'd2}
        };
        logic found, wen, vld_after, busy_acc;
        logic [31:0] res;
        logic [4:0]  rd;
        int lat, busy_cnt;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(ops[i].f3, ops[i].a, ops[i].b, 5'd20 + 5'(i), ops[i].res, 1'b1, busy_acc);
            wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
            e = sb.pop_front();
            n_cmp++;
            if ({found, res} !== {1'b1, e.res}) begin
                n_fail++; $display("[TB] FAIL div_res[%0d]: got found=%b res=%h expected %h", i, found, res, e.res);
            end
            n_cmp++;
            if (lat !== 34) begin n_fail++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
        end
    endtask

    task automatic test_div_fast();
        op_t ops[4] = '{
            '{F3_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF},
            '{F3_REM, 32'd5,         32'd0,         32'd5},
            '{F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
        };
        logic found, wen, vld_after, busy_acc;
        logic [31:0] res;
        logic [4:0]  rd;
        int lat, busy_cnt;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(ops[i].f3, ops[i].a, ops[i].b, 5'd1, ops[i].res, 1'b1, busy_acc);
            wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
            e = sb.pop_front();
            n_cmp++;
            if ({found, res} !== {1'b1, e.res}) begin
                n_fail++; $display("[TB] FAIL fast_res[%0d]: got found=%b res=%h expected %h", i, found, res, e.res);
            end
            n_cmp++;
            if (lat !== 2) begin n_fail++; $display("[TB] FAIL fast_latency[%0d]: got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_flush();
        logic found, wen, vld_after, busy_acc;
        logic [31:0] res;
        logic [4:0]  rd;
        int lat, busy_cnt, seen;
        exp_t e;
        apply_stimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'd0, 1'b0, busy_acc);
        repeat (9) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle: got busy=%b expected 0", bus.o_busy); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.o_vld) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_fail++; $display("[TB] FAIL flush_no_vld: got %0d beats expected 0", seen); end
        apply_stimulus(F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1, busy_acc);
        wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
        e = sb.pop_front();
        n_cmp++;
        if ({found, res, lat} !== {1'b1, e.res, 32'd34}) begin
            n_fail++; $display("[TB] FAIL after_flush: got found=%b res=%h lat=%0d expected %h lat 34", found, res, lat, e.res);
        end
    endtask

    task automatic test_reset_mid();
        logic busy_acc;
        int seen;
        apply_stimulus(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'd0, 1'b0, busy_acc);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_busy, bus.o_vld, bus.o_rd_wen, bus.o_res, bus.o_rd_waddr} !== 40'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: got busy=%b vld=%b wen=%b res=%h rd=%0d expected all 0",
                     bus.o_busy, bus.o_vld, bus.o_rd_wen, bus.o_res, bus.o_rd_waddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.o_vld) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_fail++; $display("[TB] FAIL reset_no_vld: got %0d beats expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic found, wen, vld_after, busy_prev, advanced;
        logic [31:0] res;
        logic [4:0]  rd;
        int lat, busy_cnt;
        exp_t e;
        e.res = 32'd14; e.rd = 5'd3; e.wen = 1'b1;
        sb.push_back(e);
        bus.i_vld = 1'b1; bus.i_funct3 = F3_DIVU; bus.i_op_a = 32'd100;
        bus.i_op_b = 32'd7; bus.i_rd_waddr = 5'd3;
        advanced = 1'b0;
        for (int k = 0; k < 60 && !advanced; k++) begin
            #1 busy_prev = bus.o_busy;
            @(negedge clk);
            if (!busy_prev && k > 0) advanced = 1'b1;
        end
        n_cmp++;
        if (advanced !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_timeout: busy never released"); end
        bus.i_funct3 = F3_MUL; bus.i_op_a = 32'd6; bus.i_op_b = 32'd7; bus.i_rd_waddr = 5'd0;
        e.res = 32'd42; e.rd = 5'd0; e.wen = 1'b0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({bus.o_vld, bus.o_res, bus.o_rd_waddr, bus.o_rd_wen} !== {1'b1, e.res, e.rd, e.wen}) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got vld=%b res=%h rd=%0d wen=%b expected vld=1 res=%h rd=%0d wen=%b",
                     bus.o_vld, bus.o_res, bus.o_rd_waddr, bus.o_rd_wen, e.res, e.rd, e.wen);
        end
        n_cmp++;
        if (bus.o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept: got busy=%b expected 1", bus.o_busy); end
        @(negedge clk);
        bus.i_vld = 1'b0;
        wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
        e = sb.pop_front();
        n_cmp++;
        if ({found, res, lat} !== {1'b1, e.res, 32'd34}) begin
            n_fail++; $display("[TB] FAIL b2b_second: got found=%b res=%h lat=%0d expected %h lat 34", found, res, lat, e.res);
        end
        n_cmp++;
        if ({rd, wen} !== {e.rd, e.wen}) begin
            n_fail++; $display("[TB] FAIL x0_wen: got rd=%0d wen=%b expected rd=%0d wen=%b", rd, wen, e.rd, e.wen);
        end
    endtask

    task automatic test_random();
        logic found, wen, vld_after, busy_acc, fast_exp;
        logic [31:0] res, a, b;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int lat, busy_cnt;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 1000));
            if (i == 3) b = 32'd0;
            if (i == 5) begin f3 = F3_REM; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            fast_exp = f3[2] && ((b == 0) || (((f3 == 3'd4) || (f3 == 3'd6)) &&
                                 (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
            apply_stimulus(f3, a, b, 5'd17, model(f3, a, b), 1'b1, busy_acc);
            wait_result(found, res, rd, wen, lat, busy_cnt, vld_after);
            e = sb.pop_front();
            n_cmp++;
            if ({found, res} !== {1'b1, e.res}) begin
                n_fail++;
                $display("[TB] FAIL rand_res[%0d]: f3=%0d a=%h b=%h got found=%b res=%h expected %h",
                         i, f3, a, b, found, res, e.res);
            end
            n_cmp++;
            if (lat !== (fast_exp ? 2 : 34)) begin
                n_fail++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, fast_exp ? 2 : 34);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_vld      = 1'b0;
        bus.i_funct3   = '0;
        bus.i_op_a     = '0;
        bus.i_op_b     = '0;
        bus.i_rd_waddr = '0;
        bus.i_flush    = 1'b0;
        @(negedge clk);
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_div_fast();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
